// File: rtl/spi_lcd_peripheral_rx.sv
// Receive-only SPI mode-0 peripheral for the LCD link: synchronizes the pins,
// assembles MSB-first bytes tagged with the DC flag and buffers them in a small FIFO.
module spi_lcd_peripheral_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  input  logic                 spi_cs_n,
  input  logic                 lcd_dc,
  output logic [7:0]           rx_data,
  output logic                 rx_dc,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [PTR_WIDTH:0]   rx_level,
  output logic                 rx_busy,
  output logic                 overflow,
  output logic                 frame_err,
  input  logic                 clear_err
);

  typedef enum logic [1:0] {IDLE, RECV, PUSH} state_e;

  localparam logic [PTR_WIDTH:0] FULL_LEVEL = (PTR_WIDTH+1)'(FIFO_DEPTH);

  // Synchronizer chains: bit 0 = s1, bit 1 = s2, bit 2 = s3.
  logic [2:0] sclk_q, sclk_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;
  logic [1:0] dc_q, dc_d;

  state_e               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [8:0]           stage_q, stage_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_err_q, frame_err_d;

  logic [8:0] mem [FIFO_DEPTH];

  logic sclk_rise, cs_rise, cs_low;
  logic push, pop, accept;
  logic [7:0] next_shift;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign cs_rise    = cs_q[1] & ~cs_q[2];
  assign cs_low     = ~cs_q[1];
  assign next_shift = {shift_q[6:0], mosi_q[1]};

  assign rx_valid = (count_q != '0);
  assign push     = (state_q == PUSH);
  assign pop      = rx_valid & rx_ready;
  // A full FIFO still takes the new entry when the head leaves in the same cycle.
  assign accept   = push & ((count_q != FULL_LEVEL) | pop);

  always_comb begin
    sclk_d      = {sclk_q[1:0], spi_clk};
    cs_d        = {cs_q[1:0], spi_cs_n};
    mosi_d      = {mosi_q[0], spi_mosi};
    dc_d        = {dc_q[0], lcd_dc};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stage_d     = stage_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_low) state_d = RECV;
      end
      RECV: begin
        if (cs_rise) begin
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else if (sclk_rise && cs_low) begin
          shift_d = next_shift;
          if (bit_cnt_q == 4'd7) begin
            stage_d   = {dc_q[1], next_shift};
            bit_cnt_d = '0;
            state_d   = PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PUSH: state_d = cs_low ? RECV : IDLE;
      default: state_d = IDLE;
    endcase

    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear wins over a same-cycle drop.
    if (clear_err)             overflow_d = 1'b0;
    else if (push && !accept)  overflow_d = 1'b1;
    else                       overflow_d = overflow_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q      <= '0;
      cs_q        <= '1;  // idle = deselected, keeps rx_busy low in reset
      mosi_q      <= '0;
      dc_q        <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      stage_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      dc_q        <= dc_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      stage_q     <= stage_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the reset pointers and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= stage_q;
  end

  assign rx_data   = rx_valid ? mem[rd_ptr_q][7:0] : 8'h00;
  assign rx_dc     = rx_valid ? mem[rd_ptr_q][8] : 1'b0;
  assign rx_level  = count_q;
  assign rx_busy   = cs_low;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_lcd_peripheral_rx.sv
// Directed bench for spi_lcd_peripheral_rx: table of single-byte transfers plus
// hand-written sequences for ordering, overflow, framing errors and mid-byte reset.
module tb_spi_lcd_peripheral_rx;

  localparam int H = 4;  // SPI half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, lcd_dc = 1'b0;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, rx_busy, overflow, frame_err;
  logic       rx_ready = 1'b0, clear_err = 1'b0;
  logic [2:0] rx_level;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] popq[$];
  int         pop_rd = 0;
  int         valid_cycles = 0;
  int         ferr_cycles = 0;

  always #5 clk = ~clk;

  spi_lcd_peripheral_rx #(.FIFO_DEPTH(4), .PTR_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .rx_busy(rx_busy), .overflow(overflow),
    .frame_err(frame_err), .clear_err(clear_err)
  );

  // Outputs observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) popq.push_back({rx_dc, rx_data});
      if (frame_err) ferr_cycles++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [8:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shift the top nbits of data MSB first; optionally raise rx_ready for exactly
  // the cycle in which the completed byte is written (3 edges after the 8th rise is sampled).
  task automatic spi_xfer(input logic [7:0] data, input logic dc, input int nbits,
                          input bit pop_on_push = 1'b0);
    spi_cs_n = 1'b0;
    lcd_dc   = dc;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[7-i];
      tick(H);
      spi_clk = 1'b1;
      if (pop_on_push && i == 7) begin
        tick(3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end else begin
        tick(H);
      end
      spi_clk = 1'b0;
    end
    tick(H);
    spi_cs_n = 1'b1;
    tick(2 * H);
  endtask

  task automatic expect_pop(input string name, input logic [8:0] exp);
    int budget = 60;
    while (popq.size() <= pop_rd && budget > 0) begin
      tick(1);
      budget--;
    end
    check(name, (popq.size() > pop_rd) ? {23'h0, popq[pop_rd]} : 32'hFFFF_FFFF, {23'h0, exp});
    pop_rd++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_dc"}, rx_dc, 0);
    check({tag, "_level"}, rx_level, 0);
    check({tag, "_busy"}, rx_busy, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   v0, f0;
    vecs[0] = '{data: 8'hA5, dc: 1'b1, exp: 9'h1A5};
    vecs[1] = '{data: 8'h00, dc: 1'b0, exp: 9'h000};
    vecs[2] = '{data: 8'hFF, dc: 1'b1, exp: 9'h1FF};
    vecs[3] = '{data: 8'h3C, dc: 0,    exp: 9'h03C};
    vecs[4] = '{data: 8'h81, dc: 1'b1, exp: 9'h181};

    // Reset state
    tick(3);
    check_reset_values("reset");
    reset_n = 1'b1;
    tick(3);

    // Table: single bytes drained immediately
    rx_ready = 1'b1;
    foreach (vecs[k]) begin
      v0 = valid_cycles;
      f0 = ferr_cycles;
      spi_xfer(vecs[k].data, vecs[k].dc, 8);
      expect_pop($sformatf("vec%0d_pop", k), vecs[k].exp);
      tick(4);
      check($sformatf("vec%0d_valid_cycles", k), valid_cycles - v0, 1);
      check($sformatf("vec%0d_ferr", k), ferr_cycles - f0, 0);
      check($sformatf("vec%0d_ovf", k), overflow, 0);
      check($sformatf("vec%0d_level", k), rx_level, 0);
    end

    // Two windows buffered, then drained in order
    rx_ready = 1'b0;
    spi_xfer(8'h3C, 1'b0, 8);
    spi_xfer(8'hC3, 1'b1, 8);
    check("two_level", rx_level, 2);
    check("two_head", {rx_dc, rx_data}, 9'h03C);
    rx_ready = 1'b1;
    expect_pop("two_pop0", 9'h03C);
    expect_pop("two_pop1", 9'h1C3);
    tick(2);
    check("two_empty", rx_level, 0);

    // Overflow: five bytes into a depth-4 FIFO
    rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) spi_xfer(8'(b), 1'b0, 8);
    check("ovf_level4", rx_level, 4);
    check("ovf_not_yet", overflow, 0);
    spi_xfer(8'h05, 1'b0, 8);
    check("ovf_level_after5", rx_level, 4);
    check("ovf_set", overflow, 1);
    rx_ready = 1'b1;
    for (int b = 1; b <= 4; b++) expect_pop($sformatf("ovf_pop%0d", b), 9'(b));
    tick(3);
    check("ovf_drained", rx_level, 0);
    check("ovf_sticky", overflow, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    check("ovf_cleared", overflow, 0);

    // Framing error: partial byte then a full one
    rx_ready = 1'b0;
    f0 = ferr_cycles;
    spi_xfer(8'hF8, 1'b1, 5);
    check("ferr_pulse", ferr_cycles - f0, 1);
    check("ferr_no_entry", rx_level, 0);
    spi_xfer(8'h81, 1'b1, 8);
    check("ferr_total", ferr_cycles - f0, 1);
    check("ferr_level", rx_level, 1);
    rx_ready = 1'b1;
    expect_pop("ferr_pop", 9'h181);
    tick(2);

    // Full FIFO, pop and push land on the same cycle
    rx_ready = 1'b0;
    spi_xfer(8'h11, 1'b0, 8);
    spi_xfer(8'h22, 1'b1, 8);
    spi_xfer(8'h33, 1'b0, 8);
    spi_xfer(8'h44, 1'b1, 8);
    check("simul_full", rx_level, 4);
    spi_xfer(8'h77, 1'b1, 8, 1'b1);
    check("simul_ovf", overflow, 0);
    check("simul_level", rx_level, 4);
    expect_pop("simul_pop0", 9'h011);
    rx_ready = 1'b1;
    expect_pop("simul_pop1", 9'h122);
    expect_pop("simul_pop2", 9'h033);
    expect_pop("simul_pop3", 9'h144);
    expect_pop("simul_pop4", 9'h177);
    tick(3);
    check("simul_empty", rx_level, 0);

    // Reset in the middle of a byte, with one entry already buffered
    rx_ready = 1'b0;
    spi_xfer(8'h99, 1'b1, 8);
    check("rst_prefill", rx_level, 1);
    f0 = ferr_cycles;
    spi_cs_n = 1'b0;
    lcd_dc   = 1'b1;
    tick(H);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = i[0];
      tick(H);
      spi_clk = 1'b1;
      tick(H);
      spi_clk = 1'b0;
    end
    check("rst_busy_before", rx_busy, 1);
    reset_n = 1'b0;
    tick(2);
    check_reset_values("midrst");
    spi_cs_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    spi_xfer(8'h5A, 1'b0, 8);
    check("rst_level", rx_level, 1);
    check("rst_no_ferr", ferr_cycles - f0, 0);
    rx_ready = 1'b1;
    expect_pop("rst_pop", 9'h05A);
    tick(3);
    check("rst_empty", rx_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
